sh7604_dreq_fifo_target: RTL and testbench
==========================================

Name: sh7604_dreq_fifo_target

Overview:
- External-bus DMA source device: the far end of the SH7604 DMAC's DREQ/DACK handshake and its DBUS cycles.
- A local producer pushes longwords into a FIFO. The block raises DREQ when enough data is buffered.
- The block answers DMAC single or 16-byte-burst reads with programmable wait states and an end-of-burst strobe.
- Used in SH/SCU-side simulation and as the template for peripheral DMA sources.

Parameters:
- DEPTH, 16, FIFO depth in longwords; power of two, ≥4.
- BASE, 32'h02000000, register window base address; 16-byte aligned.
- WAIT_STATES, 2, extra wait cycles before each data beat, 0..7.
- DL_INIT, 1'b0, reset value of the DREQ active level (0 = active-low).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE  in  1  clock enable; all state advances only when CE=1
- PUSH  in  1  producer write strobe
- PUSH_DATA  in  32  producer data
- FULL  out  1  FIFO full
- LEVEL  out  $clog2(DEPTH)+1  current entry count
- BUS_A  in  32  initiator address
- BUS_WDATA  in  32  initiator write data
- BUS_RDATA  out  32  read data to initiator
- BUS_BA  in  4  byte lanes
- BUS_WE  in  1  write cycle
- BUS_REQ  in  1  cycle request
- BUS_BURST  in  1  4-beat longword burst
- BUS_WAIT  out  1  hold-off to initiator
- BUS_END  out  1  one-CE pulse on the final beat of a cycle
- DACK  in  1  DMAC acknowledge, active level = CTRL.AL
- DREQ  out  1  DMA request, active level = CTRL.DL
- OVF  out  1  sticky overflow
- UNF  out  1  sticky underflow

Behaviour:
- Register map (longword only):
  - BASE+0 DATA: a read pops one entry; writes are ignored.
  - BASE+4 STAT = {16'h0, OVF, UNF, 14'h0 | LEVEL}. Write-1-to-clear on bits 15:14.
  - BASE+8 CTRL: bit0 DE (DREQ enable), bit1 BM (burst mode, threshold 4), bit2 DL, bit3 AL. Reset 4'b0 with DL=DL_INIT.
- Address select: BUS_A[31:4]==BASE[31:4]. Accesses outside the window are ignored; BUS_WAIT and BUS_END stay 0.
- Reset state:
  - FIFO empty; OVF=UNF=0; state IDLE.
  - BUS_RDATA=0, BUS_WAIT=0, BUS_END=0.
  - DREQ = inactive level (~DL_INIT).
- State machine (advances on CE only):
  - IDLE: on BUS_REQ & select, load wait counter=WAIT_STATES and beat counter=BUS_BURST?3:0, go to WAITST (or DATA if WAIT_STATES=0).
  - WAITST: decrement the counter; at 0 go to DATA.
  - DATA: drive BUS_RDATA and perform the pop or register access. If beat counter=0, pulse BUS_END and go to IDLE. Otherwise decrement it, reload the wait counter, and go to WAITST.
- BUS_WAIT = BUS_REQ & select & (state≠DATA), combinational. Latency from request to first data is WAIT_STATES+1 CE cycles.
- A burst to STAT or CTRL returns or writes the same register on every beat.
- Empty pop: BUS_RDATA=32'h0, UNF set, FIFO pointers unchanged.
- Push when full with no simultaneous pop: data dropped, OVF set.
- Push and pop in the same CE cycle when full: both succeed and LEVEL is unchanged.
- Push and pop in the same CE cycle when empty: the pop underflows (UNF set) and the push is stored.
- BUS_BA is ignored for DATA; a byte or word read still pops a whole entry.
- Requests during a non-IDLE state are not re-latched.
- DREQ generation:
  - req = DE & (LEVEL ≥ (BM?4:1)); DREQ = req ? DL : ~DL, registered.
  - When DACK is active during a DATA beat, the registered DREQ uses LEVEL after that pop. This guarantees DREQ deasserts on the last permitted unit, with no over-request.
- RST asserted mid-cycle: immediate return to IDLE, BUS_WAIT=0, FIFO flushed.
- Pointer wrap: $clog2(DEPTH)+1-bit read and write pointers; full/empty by MSB compare.

Decomposition:
- Shared package SH7604_PKG gains:
  - a CTRL_t packed struct (DE, BM, DL, AL);
  - a TGT_STATE_t enum {IDLE, WAITST, DATA};
  - register offset constants.
- One sub-module: sh_sync_fifo (parameterised DEPTH/width, push/pop/level/full/empty), reusable by future sink peripherals.

Test Plan:
- Push 3 words (11,22,33), DE=1, BM=0, DL=0, single reads at BASE with WAIT_STATES=2:
  - DREQ low after the first push;
  - each read shows BUS_WAIT high for 3 cycles, then returns 11, 22, 33;
  - DREQ high again after the third DACK-qualified beat.
- BM=1, push 4 words, BUS_BURST=1 read: DREQ asserts only when LEVEL reaches 4; four beats return in order; BUS_END pulses only on beat 4; LEVEL=0.
- Read DATA with the FIFO empty: returns 0, STAT bit14=1. Writing 0x4000 to STAT clears UNF.
- Fill to DEPTH, push again: OVF=1, LEVEL=DEPTH. Push and pop in the same cycle: LEVEL stays DEPTH, the popped word is the oldest.
- Assert RST during the WAITST of a burst: the next cycle has BUS_WAIT=0, LEVEL=0, DREQ at the inactive level, CTRL=0.
- WAIT_STATES=0 and CE toggling every other cycle: data is returned exactly 1 CE cycle after the request; no state change occurs on CE=0 cycles.

Source files
------------

// File: rtl/sh7604_pkg.sv
// Shared SH7604 peripheral definitions: control register layout, bus-target
// states and register offsets within a 16-byte window.
package sh7604_pkg;

    typedef struct packed {
        logic al;
        logic dl;
        logic bm;
        logic de;
    } CTRL_t;

    typedef enum logic [1:0] {
        IDLE,
        WAITST,
        DATA
    } TGT_STATE_t;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    localparam int BURST_THRESHOLD = 4;

endpackage

// File: rtl/sh_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop on empty is ignored and a
// push on full only lands when a pop frees the slot in the same cycle.
module sh_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ce_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             doPush, doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign level_o = wrPtr_q - rdPtr_q;
    assign data_o  = mem_q[rdPtr_q[AW-1:0]];

    assign doPop  = ce_i && pop_i && !empty_o;
    assign doPush = ce_i && push_i && (!full_o || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + (AW+1)'(1);
        if (doPop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // When full, the write slot equals the head slot; the head is read
    // combinationally before this edge, so the popped word is the oldest.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/sh7604_dreq_fifo_target.sv
// DMA source peripheral answering SH7604 DMAC DREQ/DACK transfers from a
// producer-filled FIFO, with programmable wait states per data beat.
module sh7604_dreq_fifo_target
    import sh7604_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE        = 32'h0200_0000,
    parameter int          WAIT_STATES = 2,
    parameter logic        DL_INIT     = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ce_i,
    input  logic                   push_i,
    input  logic [31:0]            push_data_i,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o,
    input  logic [31:0]            bus_a_i,
    input  logic [31:0]            bus_wdata_i,
    output logic [31:0]            bus_rdata_o,
    input  logic [3:0]             bus_ba_i,
    input  logic                   bus_we_i,
    input  logic                   bus_req_i,
    input  logic                   bus_burst_i,
    output logic                   bus_wait_o,
    output logic                   bus_end_o,
    input  logic                   dack_i,
    output logic                   dreq_o,
    output logic                   ovf_o,
    output logic                   unf_o
);

    localparam int            LW         = $clog2(DEPTH) + 1;
    localparam logic [2:0]    WAIT_INIT  = 3'(WAIT_STATES);
    localparam logic [LW-1:0] THR_BURST  = LW'(BURST_THRESHOLD);
    localparam logic [LW-1:0] THR_SINGLE = LW'(1);

    TGT_STATE_t  state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  regSel_q, regSel_d;
    logic        write_q, write_d;
    CTRL_t       ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        dreq_q, dreq_d;

    logic          select, beatActive, popReq, dackActive, dmaReq;
    logic          fifoFull, fifoEmpty;
    logic [31:0]   fifoHead, statWord, ctrlWord;
    logic [LW-1:0] fifoLevel, dreqLevel;
    logic          unusedBits;

    assign unusedBits = ^{bus_ba_i, bus_a_i[1:0], bus_wdata_i[31:16], bus_wdata_i[13:4]};

    assign select     = (bus_a_i[31:4] == BASE[31:4]);
    assign beatActive = (state_q == DATA);
    assign popReq     = beatActive && !write_q && (regSel_q == REG_DATA);

    sh_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ce_i    (ce_i),
        .push_i  (push_i),
        .pop_i   (popReq),
        .data_i  (push_data_i),
        .data_o  (fifoHead),
        .level_o (fifoLevel),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign statWord = {16'h0, ovf_q, unf_q, 14'(fifoLevel)};
    assign ctrlWord = {28'h0, ctrl_q};

    assign bus_wait_o = bus_req_i && select && !beatActive && !rst_i;
    assign bus_end_o  = beatActive && (beat_q == 2'd0);

    always_comb begin
        bus_rdata_o = '0;
        if (beatActive && !write_q) begin
            case (regSel_q)
                REG_DATA: bus_rdata_o = fifoEmpty ? 32'h0 : fifoHead;
                REG_STAT: bus_rdata_o = statWord;
                REG_CTRL: bus_rdata_o = ctrlWord;
                default:  bus_rdata_o = '0;
            endcase
        end
    end

    // An acknowledged pop is discounted up front so DREQ drops on the last
    // unit the DMAC is allowed to take instead of one beat late.
    assign dackActive = (dack_i == ctrl_q.al);
    assign dreqLevel  = (dackActive && popReq && !fifoEmpty) ? fifoLevel - LW'(1) : fifoLevel;
    assign dmaReq     = ctrl_q.de && (dreqLevel >= (ctrl_q.bm ? THR_BURST : THR_SINGLE));
    assign dreq_d     = dmaReq ? ctrl_q.dl : !ctrl_q.dl;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        beat_d   = beat_q;
        regSel_d = regSel_q;
        write_d  = write_q;
        ctrl_d   = ctrl_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        case (state_q)
            IDLE: begin
                if (bus_req_i && select) begin
                    wait_d   = WAIT_INIT;
                    beat_d   = bus_burst_i ? 2'd3 : 2'd0;
                    regSel_d = bus_a_i[3:2];
                    write_d  = bus_we_i;
                    state_d  = (WAIT_INIT == 3'd0) ? DATA : WAITST;
                end
            end
            WAITST: begin
                wait_d = wait_q - 3'd1;
                if (wait_q <= 3'd1) state_d = DATA;
            end
            DATA: begin
                if (write_q && regSel_q == REG_CTRL) ctrl_d = CTRL_t'(bus_wdata_i[3:0]);
                if (write_q && regSel_q == REG_STAT) begin
                    if (bus_wdata_i[15]) ovf_d = 1'b0;
                    if (bus_wdata_i[14]) unf_d = 1'b0;
                end
                if (beat_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    beat_d  = beat_q - 2'd1;
                    wait_d  = WAIT_INIT;
                    state_d = (WAIT_INIT == 3'd0) ? DATA : WAITST;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push_i && fifoFull && !popReq) ovf_d = 1'b1;
        if (popReq && fifoEmpty)           unf_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            beat_q   <= '0;
            regSel_q <= REG_DATA;
            write_q  <= 1'b0;
            ctrl_q   <= CTRL_t'({1'b0, DL_INIT, 2'b00});
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dreq_q   <= !DL_INIT;
        end else if (ce_i) begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            beat_q   <= beat_d;
            regSel_q <= regSel_d;
            write_q  <= write_d;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dreq_q   <= dreq_d;
        end
    end

    assign full_o  = fifoFull;
    assign level_o = fifoLevel;
    assign dreq_o  = dreq_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: tb/tb_sh7604_dreq_fifo_target.sv
// Scoreboard bench: pushed words queue up as expected read data and are
// compared as the target returns them; a second instance runs with no waits.
module tb_sh7604_dreq_fifo_target;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0200_0000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;

    logic        clk;
    logic        rst, ce, push, busWe, busReq, busBurst, dack;
    logic [31:0] pushData, busA, busWdata;
    logic [3:0]  busBa;
    logic        full, busWait, busEnd, dreq, ovf, unf;
    logic [4:0]  level;
    logic [31:0] busRdata;

    logic        ce0, req0;
    logic        full0, wait0, end0, dreq0, ovf0, unf0;
    logic [4:0]  level0;
    logic [31:0] rdata0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model[$];
    logic [31:0] model0[$];
    logic        mOvf, mUnf;
    logic [3:0]  mCtrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sh7604_dreq_fifo_target #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_STATES(2), .DL_INIT(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .push_i(push), .push_data_i(pushData),
        .full_o(full), .level_o(level), .bus_a_i(busA), .bus_wdata_i(busWdata),
        .bus_rdata_o(busRdata), .bus_ba_i(busBa), .bus_we_i(busWe), .bus_req_i(busReq),
        .bus_burst_i(busBurst), .bus_wait_o(busWait), .bus_end_o(busEnd), .dack_i(dack),
        .dreq_o(dreq), .ovf_o(ovf), .unf_o(unf)
    );

    sh7604_dreq_fifo_target #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_STATES(0), .DL_INIT(1'b0)) dutNoWait (
        .clk_i(clk), .rst_i(rst), .ce_i(ce0), .push_i(push), .push_data_i(pushData),
        .full_o(full0), .level_o(level0), .bus_a_i(busA), .bus_wdata_i(busWdata),
        .bus_rdata_o(rdata0), .bus_ba_i(busBa), .bus_we_i(busWe), .bus_req_i(req0),
        .bus_burst_i(busBurst), .bus_wait_o(wait0), .bus_end_o(end0), .dack_i(dack),
        .dreq_o(dreq0), .ovf_o(ovf0), .unf_o(unf0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] modelStat();
        return {16'h0, mOvf, mUnf, 14'(model.size())};
    endfunction

    task automatic applyStimulus(input logic [31:0] d);
        @(negedge clk);
        push = 1'b1;
        pushData = d;
        if (model.size() < DEPTH) model.push_back(d);
        else mOvf = 1'b1;
        @(negedge clk);
        push = 1'b0;
    endtask

    // One complete initiator transaction; every beat is scored against the model.
    task automatic busCycle(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                            input logic burst, input logic dackOn, input logic pushOn,
                            input logic [31:0] pd, input int expWaits);
        int beats, beat, waits, cycles;
        logic [31:0] want;
        beats = burst ? 4 : 1;
        beat = 0;
        waits = 0;
        cycles = 0;
        @(negedge clk);
        busA = addr;
        busWe = we;
        busWdata = wdata;
        busBurst = burst;
        busReq = 1'b1;
        dack = dackOn ? 1'b0 : 1'b1;
        push = pushOn;
        pushData = pd;
        while (beat < beats && cycles < 64) begin
            #1;
            if (busWait) begin
                waits++;
            end else begin
                if (beat == 0 && expWaits >= 0) checkOutput("waitCycles", 32'(waits), 32'(expWaits));
                want = 32'h0;
                if (!we) begin
                    case (addr[3:2])
                        2'd0: begin
                            if (model.size() > 0) want = model.pop_front();
                            else mUnf = 1'b1;
                        end
                        2'd1: want = modelStat();
                        2'd2: want = {28'h0, mCtrl};
                        default: want = 32'h0;
                    endcase
                end else begin
                    if (addr[3:2] == 2'd1) begin
                        if (wdata[15]) mOvf = 1'b0;
                        if (wdata[14]) mUnf = 1'b0;
                    end
                    if (addr[3:2] == 2'd2) mCtrl = wdata[3:0];
                end
                checkOutput("rdata", busRdata, want);
                checkOutput("busEnd", 32'(busEnd), 32'(beat == beats - 1));
                beat++;
            end
            if (push) begin
                if (model.size() < DEPTH) model.push_back(pushData);
                else mOvf = 1'b1;
            end
            cycles++;
            @(negedge clk);
        end
        if (beat < beats) checkOutput("beatTimeout", 32'(beat), 32'(beats));
        busReq = 1'b0;
        busBurst = 1'b0;
        busWe = 1'b0;
        dack = 1'b1;
        push = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] want0;
        rst = 1'b1; ce = 1'b1; push = 1'b0; pushData = '0;
        busA = '0; busWdata = '0; busBa = 4'hF; busWe = 1'b0; busReq = 1'b0; busBurst = 1'b0;
        dack = 1'b1; ce0 = 1'b0; req0 = 1'b0;
        mOvf = 1'b0; mUnf = 1'b0; mCtrl = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstLevel", 32'(level), 32'd0);
        checkOutput("rstFull", 32'(full), 32'd0);
        checkOutput("rstWait", 32'(busWait), 32'd0);
        checkOutput("rstEnd", 32'(busEnd), 32'd0);
        checkOutput("rstRdata", busRdata, 32'h0);
        checkOutput("rstDreq", 32'(dreq), 32'd1);
        checkOutput("rstFlags", {30'h0, ovf, unf}, 32'h0);

        // Single reads, DREQ active-low with threshold 1.
        busCycle(A_CTRL, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 3);
        applyStimulus(32'h11);
        @(negedge clk); #1;
        checkOutput("dreqAfterPush", 32'(dreq), 32'd0);
        applyStimulus(32'h22);
        applyStimulus(32'h33);
        #1 checkOutput("levelThree", 32'(level), 32'd3);
        busCycle(A_DATA, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 3);
        #1 checkOutput("dreqHeld", 32'(dreq), 32'd0);
        busCycle(A_DATA, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 3);
        busCycle(A_DATA, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 3);
        #1 checkOutput("dreqReleased", 32'(dreq), 32'd1);

        // Burst mode: request only once four words are buffered.
        busCycle(A_CTRL, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0, 3);
        for (int i = 0; i < 3; i++) applyStimulus(32'hA1 + 32'(i));
        @(negedge clk); #1;
        checkOutput("dreqBelowThr", 32'(dreq), 32'd1);
        applyStimulus(32'hA4);
        @(negedge clk); #1;
        checkOutput("dreqAtThr", 32'(dreq), 32'd0);
        busCycle(A_DATA, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 3);
        #1;
        checkOutput("burstLevel", 32'(level), 32'd0);
        checkOutput("burstDreq", 32'(dreq), 32'd1);

        // Underflow and write-1-to-clear.
        busCycle(A_DATA, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3);
        #1 checkOutput("unfSet", 32'(unf), 32'd1);
        busCycle(A_STAT, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3);
        busCycle(A_STAT, 1'b1, 32'h4000, 1'b0, 1'b0, 1'b0, 32'h0, 3);
        busCycle(A_STAT, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3);
        #1 checkOutput("unfCleared", 32'(unf), 32'd0);

        // Fill, overflow, then simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) applyStimulus($urandom);
        #1;
        checkOutput("fullFlag", 32'(full), 32'd1);
        checkOutput("fullLevel", 32'(level), 32'(DEPTH));
        applyStimulus(32'hDEAD_BEEF);
        #1;
        checkOutput("ovfSet", 32'(ovf), 32'd1);
        checkOutput("ovfLevel", 32'(level), 32'(DEPTH));
        busCycle(A_DATA, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFEED_0001, 3);
        #1 checkOutput("pushPopLevel", 32'(level), 32'(DEPTH));
        busCycle(A_STAT, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3);

        // Reset while a burst sits in its wait states.
        @(negedge clk);
        busA = A_DATA; busBurst = 1'b1; busWe = 1'b0; busReq = 1'b1;
        @(negedge clk); #1;
        checkOutput("waitInWaitst", 32'(busWait), 32'd1);
        rst = 1'b1;
        #1 checkOutput("waitDuringRst", 32'(busWait), 32'd0);
        @(negedge clk);
        rst = 1'b0; busReq = 1'b0; busBurst = 1'b0;
        model.delete();
        mOvf = 1'b0; mUnf = 1'b0; mCtrl = 4'h0;
        #1;
        checkOutput("postRstWait", 32'(busWait), 32'd0);
        checkOutput("postRstLevel", 32'(level), 32'd0);
        checkOutput("postRstDreq", 32'(dreq), 32'd1);
        checkOutput("postRstOvf", 32'(ovf), 32'd0);
        busCycle(A_CTRL, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 3);

        // Zero-wait instance with CE toggling every other cycle.
        ce = 1'b0;
        @(negedge clk);
        ce0 = 1'b1; push = 1'b1; pushData = 32'hA5A5_0006;
        model0.push_back(pushData);
        @(negedge clk);
        ce0 = 1'b0; push = 1'b0; busA = A_DATA; busWe = 1'b0; req0 = 1'b1;
        #1;
        checkOutput("ce0IdleWait", 32'(wait0), 32'd1);
        checkOutput("ce0Level", 32'(level0), 32'd1);
        @(negedge clk);
        ce0 = 1'b1;
        #1 checkOutput("ce0NoAdvance", 32'(wait0), 32'd1);
        @(negedge clk);
        ce0 = 1'b0;
        #1;
        want0 = (model0.size() > 0) ? model0.pop_front() : 32'h0;
        checkOutput("ce0Wait", 32'(wait0), 32'd0);
        checkOutput("ce0Rdata", rdata0, want0);
        checkOutput("ce0End", 32'(end0), 32'd1);
        @(negedge clk);
        ce0 = 1'b1;
        #1;
        checkOutput("ce0RdataHeld", rdata0, want0);
        checkOutput("ce0NoPop", 32'(level0), 32'd1);
        @(negedge clk);
        ce0 = 1'b0; req0 = 1'b0;
        #1;
        checkOutput("ce0Popped", 32'(level0), 32'd0);
        checkOutput("ce0EndDone", 32'(end0), 32'd0);
        checkOutput("ce0RdataIdle", rdata0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
